// File: rtl/cachepkg.sv
// Shared cache-side types: the operation encoding and the port arbiter's FSM state.
package cachepkg;

  typedef enum logic [1:0] {
    READ  = 2'd0,
    WRITE = 2'd1,
    FLUSH = 2'd2,
    NOP   = 2'd3
  } inst_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2,
    DONE = 2'd3
  } arb_state_t;

  // Grant index held in reset, chosen so requester 0 wins the first round-robin pick.
  function automatic int unsigned arb_reset_grant(int unsigned numreq);
    return numreq - 1;
  endfunction

endpackage

// File: rtl/cache_port_arbiter_rr_pick.sv
// Combinational round-robin picker: scans requesters starting one past the last grant.
module cache_port_arbiter_rr_pick #(
  parameter int unsigned NUMREQ = 2,
  localparam int unsigned GW = $clog2(NUMREQ)
) (
  input  logic [NUMREQ-1:0] req_i,
  input  logic [GW-1:0]     last_i,
  output logic [GW-1:0]     winner_o,
  output logic              any_o
);

  logic [GW-1:0] idx;

  // Walk from the farthest offset down so the nearest pending requester is assigned last.
  always_comb begin
    winner_o = '0;
    any_o    = 1'b0;
    idx      = '0;
    for (int i = NUMREQ; i >= 1; i--) begin
      idx = GW'((int'(last_i) + i) % int'(NUMREQ));
      if (req_i[idx]) begin
        winner_o = idx;
        any_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cache_port_arbiter.sv
// Shares one cache slave port between NUMREQ requesters with round-robin grant and
// one 4-phase request/valid transaction in flight at a time.
module cache_port_arbiter
  import cachepkg::*;
#(
  parameter int unsigned NUMREQ       = 2,
  parameter int unsigned DATAWIDTH    = 8,
  parameter int unsigned ADDRESSWIDTH = 32,
  localparam int unsigned GW = $clog2(NUMREQ)
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [NUMREQ-1:0]                   req_request,
  input  inst_t [NUMREQ-1:0]                  req_operation,
  input  logic [NUMREQ-1:0][ADDRESSWIDTH-1:0] req_addr,
  input  logic [NUMREQ-1:0][DATAWIDTH-1:0]    req_wdata,
  output logic [NUMREQ-1:0]                   req_valid,
  output logic [NUMREQ-1:0]                   req_evict,
  output logic [DATAWIDTH-1:0]                req_rdata,
  output inst_t                               cache_operation,
  output logic [ADDRESSWIDTH-1:0]             cache_addr,
  output logic [DATAWIDTH-1:0]                cache_wdata,
  output logic                                cache_request,
  input  logic                                cache_valid,
  input  logic                                cache_evict,
  input  logic [DATAWIDTH-1:0]                cache_rdata,
  output logic [GW-1:0]                       grant_id
);

  arb_state_t              state_q, state_d;
  logic [GW-1:0]           grant_q, grant_d;
  logic                    creq_q, creq_d;
  inst_t                   op_q, op_d;
  logic [ADDRESSWIDTH-1:0] addr_q, addr_d;
  logic [DATAWIDTH-1:0]    wdata_q, wdata_d;
  logic [NUMREQ-1:0]       valid_q, valid_d;
  logic [NUMREQ-1:0]       evict_q, evict_d;
  logic [DATAWIDTH-1:0]    rdata_q, rdata_d;

  logic [GW-1:0] winner;
  logic          any_req;

  cache_port_arbiter_rr_pick #(
    .NUMREQ (NUMREQ)
  ) u_rr_pick (
    .req_i    (req_request),
    .last_i   (grant_q),
    .winner_o (winner),
    .any_o    (any_req)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    creq_d  = creq_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    valid_d = valid_q;
    evict_d = evict_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        // A still-high cache_valid belongs to the previous handshake; wait it out.
        if (any_req && !cache_valid) begin
          grant_d = winner;
          op_d    = req_operation[winner];
          addr_d  = req_addr[winner];
          wdata_d = req_wdata[winner];
          creq_d  = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (cache_valid) begin
          rdata_d          = cache_rdata;
          valid_d[grant_q] = 1'b1;
          evict_d[grant_q] = cache_evict;
          state_d          = ACK;
        end
      end
      ACK: begin
        if (!req_request[grant_q]) begin
          creq_d  = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (!cache_valid) begin
          valid_d = '0;
          evict_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= GW'(arb_reset_grant(NUMREQ));
      creq_q  <= 1'b0;
      op_q    <= READ;
      addr_q  <= '0;
      wdata_q <= '0;
      valid_q <= '0;
      evict_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      creq_q  <= creq_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      valid_q <= valid_d;
      evict_q <= evict_d;
      rdata_q <= rdata_d;
    end
  end

  assign req_valid       = valid_q;
  assign req_evict       = evict_q;
  assign req_rdata       = rdata_q;
  assign cache_operation = op_q;
  assign cache_addr      = addr_q;
  assign cache_wdata     = wdata_q;
  assign cache_request   = creq_q;
  assign grant_id        = grant_q;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed plus randomized bench for cache_port_arbiter; the bench plays both requesters
// and the cache, and predicts grants from the round-robin rule over pending requests.
module tb_cache_port_arbiter;
  import cachepkg::*;

  localparam int NR = 2;

  logic                 clock;
  logic                 reset;
  logic [NR-1:0]        req_request;
  inst_t [NR-1:0]       req_operation;
  logic [NR-1:0][31:0]  req_addr;
  logic [NR-1:0][7:0]   req_wdata;
  logic [NR-1:0]        req_valid;
  logic [NR-1:0]        req_evict;
  logic [7:0]           req_rdata;
  inst_t                cache_operation;
  logic [31:0]          cache_addr;
  logic [7:0]           cache_wdata;
  logic                 cache_request;
  logic                 cache_valid;
  logic                 cache_evict;
  logic [7:0]           cache_rdata;
  logic                 grant_id;

  cache_port_arbiter #(
    .NUMREQ       (NR),
    .DATAWIDTH    (8),
    .ADDRESSWIDTH (32)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .req_request     (req_request),
    .req_operation   (req_operation),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .req_valid       (req_valid),
    .req_evict       (req_evict),
    .req_rdata       (req_rdata),
    .cache_operation (cache_operation),
    .cache_addr      (cache_addr),
    .cache_wdata     (cache_wdata),
    .cache_request   (cache_request),
    .cache_valid     (cache_valid),
    .cache_evict     (cache_evict),
    .cache_rdata     (cache_rdata),
    .grant_id        (grant_id)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: what each requester asked for, who is pending, last winner.
  inst_t         op_m [NR];
  logic [31:0]   a_m  [NR];
  logic [7:0]    d_m  [NR];
  logic [NR-1:0] pend_m;
  int            last_m;

  task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_model(input logic [NR-1:0] p, input int last);
    for (int k = 1; k <= NR; k++) begin
      if (p[(last + k) % NR]) return (last + k) % NR;
    end
    return 0;
  endfunction

  function automatic logic [NR-1:0] one_at(input int g, input logic b);
    logic [NR-1:0] m;
    m    = '0;
    m[g] = b;
    return m;
  endfunction

  task automatic raise(input int i, input inst_t op, input logic [31:0] a, input logic [7:0] d);
    op_m[i] = op;
    a_m[i]  = a;
    d_m[i]  = d;
    req_operation[i] = op;
    req_addr[i]      = a;
    req_wdata[i]     = d;
    req_request[i]   = 1'b1;
    pend_m[i]        = 1'b1;
  endtask

  task automatic chk_reset(input string tag);
    cmp({tag, "_valid"}, req_valid, 0);
    cmp({tag, "_evict"}, req_evict, 0);
    cmp({tag, "_rdata"}, req_rdata, 0);
    cmp({tag, "_creq"}, cache_request, 0);
    cmp({tag, "_op"}, cache_operation, 0);
    cmp({tag, "_addr"}, cache_addr, 0);
    cmp({tag, "_wdata"}, cache_wdata, 0);
    cmp({tag, "_grant"}, grant_id, NR - 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_request = '0;
    cache_valid = 1'b0;
    cache_evict = 1'b0;
    cache_rdata = '0;
    pend_m = '0;
    last_m = NR - 1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // One full 4-phase transaction with 1-cycle responses from cache and requester.
  task automatic run_txn(input int g, input logic [7:0] rd, input logic ev, input int exp_lat);
    int n = 0;
    while (!cache_request && n < 10) begin
      @(negedge clock);
      n++;
    end
    cmp("txn_latency", n, exp_lat);
    cmp("txn_grant", grant_id, g);
    cmp("txn_addr", cache_addr, a_m[g]);
    cmp("txn_wdata", cache_wdata, d_m[g]);
    cmp("txn_op", cache_operation, op_m[g]);
    cmp("txn_valid_pre", req_valid, 0);
    last_m = g;
    cache_valid = 1'b1;
    cache_rdata = rd;
    cache_evict = ev;
    @(negedge clock);
    cmp("txn_valid", req_valid, one_at(g, 1'b1));
    cmp("txn_rdata", req_rdata, rd);
    cmp("txn_evict", req_evict, one_at(g, ev));
    req_request[g] = 1'b0;
    pend_m[g] = 1'b0;
    @(negedge clock);
    cmp("txn_creq_drop", cache_request, 0);
    cmp("txn_wdata_hold", cache_wdata, d_m[g]);
    cmp("txn_addr_hold", cache_addr, a_m[g]);
    cmp("txn_valid_hold", req_valid, one_at(g, 1'b1));
    cache_valid = 1'b0;
    @(negedge clock);
    cmp("txn_valid_end", req_valid, 0);
    cmp("txn_evict_end", req_evict, 0);
  endtask

  int cur, txns, w, cwait, dwait, rwait;
  logic prev_creq, prev_val, eg_pending, eg_exp;
  logic [7:0] c_rd;
  logic c_ev;

  initial begin
    req_operation = '{default: READ};
    req_addr = '0;
    req_wdata = '0;
    do_reset();
    @(negedge clock);
    chk_reset("rst");

    // Stale cache_valid in IDLE blocks the grant until it falls.
    cache_valid = 1'b1;
    raise(0, READ, 32'h0000_0040, 8'h11);
    repeat (3) begin
      @(negedge clock);
      cmp("stale_no_grant", cache_request, 0);
    end
    cache_valid = 1'b0;
    @(negedge clock);
    cmp("stale_grant", cache_request, 1);
    cmp("stale_grant_id", grant_id, 0);
    cmp("stale_addr", cache_addr, 32'h40);

    // Reset while in REQ.
    reset = 1'b1;
    @(negedge clock);
    chk_reset("rst_mid");
    reset = 1'b0;
    req_request = '0;
    pend_m = '0;
    last_m = NR - 1;
    @(negedge clock);

    raise(0, READ, 32'h0000_1000, 8'h00);
    run_txn(0, 8'hA5, 1'b0, 1);

    raise(1, WRITE, 32'hDEAD_BEEC, 8'h3C);
    run_txn(1, 8'h77, 1'b1, 1);

    // Cache keeps valid 5 cycles after the request drops while requester 1 waits.
    raise(0, FLUSH, 32'h0000_2222, 8'h01);
    raise(1, READ, 32'h0000_3333, 8'h02);
    @(negedge clock);
    cmp("hold_grant", grant_id, 0);
    cmp("hold_creq", cache_request, 1);
    cache_valid = 1'b1;
    cache_rdata = 8'h5A;
    cache_evict = 1'b0;
    @(negedge clock);
    cmp("hold_valid", req_valid, 2'b01);
    req_request[0] = 1'b0;
    pend_m[0] = 1'b0;
    repeat (5) begin
      @(negedge clock);
      cmp("hold_valid_stay", req_valid, 2'b01);
      cmp("hold_no_grant", cache_request, 0);
    end
    cache_valid = 1'b0;
    @(negedge clock);
    cmp("hold_valid_end", req_valid, 0);
    run_txn(1, 8'h96, 1'b0, 1);

    // Simultaneous requests after reset alternate 0,1,0,1.
    do_reset();
    raise(0, READ, 32'h0000_0100, 8'hA0);
    raise(1, WRITE, 32'h0000_0200, 8'hB0);
    run_txn(0, 8'h01, 1'b0, 1);
    raise(0, WRITE, 32'h0000_0104, 8'hA1);
    run_txn(1, 8'h02, 1'b1, 1);
    raise(1, READ, 32'h0000_0204, 8'hB1);
    run_txn(0, 8'h03, 1'b0, 1);
    run_txn(1, 8'h04, 1'b1, 1);

    // Randomized traffic with random cache and requester response delays.
    do_reset();
    cur = -1;
    txns = 0;
    prev_creq = 1'b0;
    prev_val = 1'b0;
    eg_pending = 1'b0;
    eg_exp = 1'b0;
    cwait = 0;
    dwait = 0;
    rwait = 0;
    c_rd = '0;
    c_ev = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (txns >= 40 && pend_m == '0 && cur < 0 && !cache_request && !cache_valid) break;
      @(negedge clock);
      cmp("rnd_onehot", ($countones(req_valid) <= 1), 1);
      if (eg_pending) begin
        cmp("rnd_nobubble", cache_request, eg_exp);
        eg_pending = 1'b0;
      end
      if (cache_request && !prev_creq) begin
        w = rr_model(pend_m, last_m);
        cmp("rnd_grant", grant_id, w);
        cmp("rnd_op", cache_operation, op_m[w]);
        cur = w;
        last_m = w;
        cwait = $urandom_range(0, 3);
      end
      if (cur >= 0) begin
        cmp("rnd_addr", cache_addr, a_m[cur]);
        cmp("rnd_wdata", cache_wdata, d_m[cur]);
      end
      if (req_valid != '0 && !prev_val) begin
        cmp("rnd_valid", req_valid, one_at(cur, 1'b1));
        cmp("rnd_rdata", req_rdata, c_rd);
        cmp("rnd_evict", req_evict, one_at(cur, c_ev));
        rwait = $urandom_range(0, 3);
      end
      if (req_valid == '0 && prev_val) begin
        cur = -1;
        txns++;
        eg_pending = 1'b1;
      end
      prev_creq = cache_request;
      prev_val  = |req_valid;
      if (cache_request && !cache_valid) begin
        if (cwait == 0) begin
          c_rd = 8'($urandom);
          c_ev = 1'($urandom);
          cache_valid = 1'b1;
          cache_rdata = c_rd;
          cache_evict = c_ev;
          dwait = $urandom_range(0, 4);
        end else cwait--;
      end else if (!cache_request && cache_valid) begin
        if (dwait == 0) cache_valid = 1'b0;
        else dwait--;
      end
      for (int i = 0; i < NR; i++) begin
        if (i == cur && req_valid[i] && req_request[i]) begin
          if (rwait == 0) begin
            req_request[i] = 1'b0;
            pend_m[i] = 1'b0;
          end else rwait--;
        end else if (!req_request[i] && !req_valid[i] && txns < 40 && $urandom_range(0, 2) == 0) begin
          raise(i, inst_t'($urandom_range(0, 3)), $urandom, 8'($urandom));
        end
      end
      if (eg_pending) eg_exp = (pend_m != '0);
    end
    cmp("rnd_completed", (txns >= 40), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
